// File: rtl/iter_signed_mult.sv
// Radix-2 shift-add WIDTH x WIDTH multiplier with per-operand signedness and valid/ready handshakes.
// Define MUL_APPROX_EN to zero the low APPROX_COLS columns of every partial product.
module iter_signed_mult #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int ACC_W = 2*WIDTH + 2;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("iter_signed_mult: WIDTH must be in 4..32");
  end
  if (APPROX_COLS < 0 || APPROX_COLS > 2*WIDTH) begin : g_bad_cols
    $error("iter_signed_mult: APPROX_COLS must be in 0..2*WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W-1:0] a_sh_p0;
  logic        [WIDTH:0]   b_sh_p0;
  logic        [CNT_W-1:0] cnt_p0;
  logic signed [ACC_W-1:0] pp;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [WIDTH:0]   a_ext;
  logic        [WIDTH:0]   b_ext;
  logic                    last;

  // Approximate mode clears the low columns of a partial product; exact build passes it through.
  function automatic logic signed [ACC_W-1:0] approx_mask(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] m;
    m = v;
`ifdef MUL_APPROX_EN
    for (int i = 0; i < ACC_W; i++) begin
      if (i < APPROX_COLS) m[i] = 1'b0;
    end
`endif
    return m;
  endfunction

  assign a_ext = {a_signed & a[WIDTH-1], a};
  assign b_ext = {b_signed & b[WIDTH-1], b};

  // The multiplicand is pre-shifted each cycle, so the current row is always a_sh_p0.
  assign last    = (cnt_p0 == CNT_W'(WIDTH));
  assign pp      = b_sh_p0[0] ? approx_mask(a_sh_p0) : '0;
  assign acc_nxt = last ? (acc_p0 - pp) : (acc_p0 + pp);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // p0: operand latch on accept, then one multiplier bit per CALC edge; the last row is the sign row.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0  <= '0;
      a_sh_p0 <= '0;
      b_sh_p0 <= '0;
      cnt_p0  <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh_p0 <= {{(ACC_W-WIDTH-1){a_ext[WIDTH]}}, a_ext};
            b_sh_p0 <= b_ext;
            acc_p0  <= '0;
            cnt_p0  <= '0;
          end
        end
        CALC: begin
          acc_p0  <= acc_nxt;
          a_sh_p0 <= a_sh_p0 <<< 1;
          b_sh_p0 <= b_sh_p0 >> 1;
          cnt_p0  <= cnt_p0 + 1'b1;
          if (last) result <= acc_nxt[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
